// File: rtl/rom_load_pkg.sv
// Shared types for the ROM download scheduler: FSM states and FIFO entry layout.
package rom_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } entry_t;

endpackage

// File: rtl/rom_load_fifo.sv
// Small synchronous FIFO holding captured download bytes until they are written.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module rom_load_fifo
    import rom_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset flushes the contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Entry storage; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rom_load_sched.sv
// ROM download scheduler: queues data_io bytes, writes them one at a time to the
// SDRAM port selected by address region, then flags completion and stretches the
// game core reset.
module rom_load_sched
    import rom_load_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [24:0] SND_BASE    = 25'h0010000,
    parameter int          ACK_TIMEOUT = 255,
    parameter logic [15:0] RESET_HOLD  = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        soft_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] wr_a,
    output logic [1:0]  wr_ds,
    output logic [15:0] wr_d,
    output logic        wr_we,
    output logic        busy,
    output logic        overflow,
    output logic        timeout,
    output logic        rom_loaded,
    output logic        core_reset
);

    localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        exit_state;
    logic          wr_q;
    logic          downl_q;
    logic          pending;
    logic          sel_p2;
    logic [TW-1:0] ack_cnt;
    logic [15:0]   rst_cnt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          downl_fall;
    logic          ack_match;
    entry_t        head;
    entry_t        in_entry;

    assign push       = ioctl_wr & ~wr_q & ioctl_downl;
    assign pop        = (state == ST_ISSUE);
    assign downl_fall = downl_q & ~ioctl_downl;
    assign in_entry   = {ioctl_addr, ioctl_dout};
    assign ack_match  = sel_p2 ? (port2_ack == port2_req) : (port1_ack == port1_req);
    // Completion is only reported once every queued byte has been written.
    assign exit_state = (pending && fifo_empty) ? ST_DONE : ST_IDLE;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    rom_load_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Previous-cycle copies of the strobe and download flag for edge detection.
    // Reset loads the live levels so a strobe held across reset is not re-captured.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_q    <= ioctl_wr;
            downl_q <= ioctl_downl;
        end else begin
            wr_q    <= ioctl_wr;
            downl_q <= ioctl_downl;
        end
    end

    // Write scheduler: one toggle-handshake write outstanding at a time.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            port1_req  <= port1_ack;
            port2_req  <= port2_ack;
            sel_p2     <= 1'b0;
            wr_we      <= 1'b0;
            wr_a       <= '0;
            wr_ds      <= '0;
            wr_d       <= '0;
            ack_cnt    <= '0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty)  state <= ST_ISSUE;
                    else if (pending) state <= ST_DONE;
                end
                ST_ISSUE: begin
                    wr_a    <= head.addr[23:1];
                    wr_ds   <= {head.addr[0], ~head.addr[0]};
                    wr_d    <= {head.data, head.data};
                    wr_we   <= 1'b1;
                    ack_cnt <= '0;
                    if (head.addr >= SND_BASE) begin
                        sel_p2    <= 1'b1;
                        port2_req <= ~port2_req;
                    end else begin
                        sel_p2    <= 1'b0;
                        port1_req <= ~port1_req;
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_match) begin
                        wr_we <= 1'b0;
                        state <= exit_state;
                    end else if (ack_cnt == ACK_LAST) begin
                        // Give up on this write; realign req so the port looks idle.
                        timeout <= 1'b1;
                        wr_we   <= 1'b0;
                        if (sel_p2) port2_req <= port2_ack;
                        else        port1_req <= port1_ack;
                        state <= exit_state;
                    end else begin
                        ack_cnt <= ack_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    rom_loaded <= 1'b1;
                    pending    <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (downl_fall)                    pending  <= 1'b1;
            if (push && fifo_full && !pop)     overflow <= 1'b1;
        end
    end

    // Core reset stretch: held while loading or on soft reset, released after the count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rst_cnt    <= RESET_HOLD;
            core_reset <= 1'b1;
        end else begin
            if (soft_reset || !rom_loaded || ioctl_downl) rst_cnt <= RESET_HOLD;
            else if (rst_cnt != 16'd0)                    rst_cnt <= rst_cnt - 16'd1;
            core_reset <= (rst_cnt != 16'd0);
        end
    end

endmodule

// File: tb/tb_rom_load_sched.sv
// Bench for rom_load_sched: acknowledge responders, a write scoreboard fed from the
// strobe stimulus, directed scenarios and randomized bursts.
module tb_rom_load_sched;

    localparam logic [24:0] SND_BASE_TB = 25'h0010000;
    localparam int          HOLD_TB     = 100;

    typedef struct packed {
        logic        p2;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wexp_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_downl = 1'b1;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        soft_reset = 1'b0;
    logic        port1_req;
    logic        port1_ack = 1'b1;
    logic        port2_req;
    logic        port2_ack = 1'b0;
    logic [22:0] wr_a;
    logic [1:0]  wr_ds;
    logic [15:0] wr_d;
    logic        wr_we;
    logic        busy;
    logic        overflow;
    logic        timeout;
    logic        rom_loaded;
    logic        core_reset;

    int    n_checks = 0;
    int    n_fail = 0;
    int    ack_delay = 2;
    bit    ack_en = 1'b1;
    int    ack_count = 0;
    int    p1_tog = 0;
    int    p2_tog = 0;
    wexp_t exp_q[$];

    rom_load_sched #(
        .FIFO_DEPTH  (4),
        .SND_BASE    (SND_BASE_TB),
        .ACK_TIMEOUT (255),
        .RESET_HOLD  (16'(HOLD_TB))
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .soft_reset  (soft_reset),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port2_req   (port2_req),
        .port2_ack   (port2_ack),
        .wr_a        (wr_a),
        .wr_ds       (wr_ds),
        .wr_d        (wr_d),
        .wr_we       (wr_we),
        .busy        (busy),
        .overflow    (overflow),
        .timeout     (timeout),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected SDRAM write for one byte, straight from the address/data rules.
    function automatic wexp_t make_exp(input logic [24:0] a, input logic [7:0] d);
        wexp_t e;
        e.p2 = (a >= SND_BASE_TB);
        e.a  = 23'(a >> 1);
        e.ds = ((a % 2) == 1) ? 2'b10 : 2'b01;
        e.d  = 16'(d) * 16'd257;
        return e;
    endfunction

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int gap, input bit accept);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (accept) exp_q.push_back(make_exp(a, d));
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap - 1) @(negedge clk_sys);
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk_sys);
            n++;
            ok = (exp_q.size() == 0) && (port1_req == port1_ack) && (port2_req == port2_ack)
                 && !busy && !wr_we;
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic on_issue(input logic p2);
        wexp_t e;
        check("issue_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("port_sel", p2, e.p2);
            check("wr_a", wr_a, e.a);
            check("wr_ds", wr_ds, e.ds);
            check("wr_d", wr_d, e.d);
            check("wr_we_on_issue", wr_we, 1'b1);
        end
        check("one_outstanding", p2 ? (port1_req == port1_ack) : (port2_req == port2_ack), 1'b1);
        if (p2) p2_tog++;
        else    p1_tog++;
    endtask

    // Acknowledge responders: answer a pending request after ack_delay extra cycles.
    initial begin
        int w1;
        int w2;
        w1 = 0;
        w2 = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ack_en && port1_req != port1_ack) begin
                if (w1 >= ack_delay) begin port1_ack = port1_req; w1 = 0; ack_count++; end
                else w1++;
            end else w1 = 0;
            if (ack_en && port2_req != port2_ack) begin
                if (w2 >= ack_delay) begin port2_ack = port2_req; w2 = 0; ack_count++; end
                else w2++;
            end else w2 = 0;
        end
    end

    // Write monitor: a req change that leaves req != ack is a new request.
    initial begin
        logic prev1;
        logic prev2;
        @(negedge clk_sys);
        prev1 = port1_req;
        prev2 = port2_req;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (port1_req != prev1 && port1_req != port1_ack) on_issue(1'b0);
                if (port2_req != prev2 && port2_req != port2_ack) on_issue(1'b1);
            end
            prev1 = port1_req;
            prev2 = port2_req;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int base;
        int t1;
        int t2;
        logic r0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_port1_req", port1_req, 1'b1);
        check("rst_port2_req", port2_req, 1'b0);
        check("rst_wr_we", wr_we, 1'b0);
        check("rst_wr_a", wr_a, 23'h0);
        check("rst_wr_ds", wr_ds, 2'b00);
        check("rst_wr_d", wr_d, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_rom_loaded", rom_loaded, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);

        // Single byte to port 1, ack 5 cycles late
        ack_delay = 5;
        t1 = p1_tog; t2 = p2_tog;
        r0 = port1_req;
        ioctl_addr = 25'h0000003; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
        exp_q.push_back(make_exp(25'h0000003, 8'hA5));
        n = 0;
        while (port1_req == r0 && n < 10) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            n++;
        end
        check("t1_latency", n, 3);
        check("t1_wr_a", wr_a, 23'h1);
        check("t1_wr_ds", wr_ds, 2'b10);
        check("t1_wr_d", wr_d, 16'hA5A5);
        base = ack_count;
        n = 0;
        while (ack_count == base && n < 100) begin
            @(posedge clk_sys); #2; n++;
        end
        check("t1_ack_seen", ack_count != base, 1'b1);
        @(negedge clk_sys);
        check("t1_wr_we_held", wr_we, 1'b1);
        @(negedge clk_sys);
        check("t1_wr_we_clear", wr_we, 1'b0);
        wait_idle("t1_drain");
        check("t1_p1_toggles", p1_tog - t1, 1);
        check("t1_p2_toggles", p2_tog - t2, 0);

        // Sound region byte goes to port 2
        ack_delay = 2;
        t1 = p1_tog; t2 = p2_tog;
        strobe(25'h0010000, 8'h3C, 2, 1'b1);
        wait_idle("t2_drain");
        check("t2_p1_toggles", p1_tog - t1, 0);
        check("t2_p2_toggles", p2_tog - t2, 1);

        // Randomized bursts, never deeper than the FIFO
        for (int b = 0; b < 20; b++) begin
            int nb;
            nb = $urandom_range(1, 4);
            ack_delay = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                logic [24:0] a;
                if ($urandom_range(0, 1) == 1) a = 25'($urandom_range(0, 32'h0000FFFF));
                else                           a = 25'($urandom_range(32'h0010000, 32'h1FFFFFF));
                strobe(a, 8'($urandom), $urandom_range(2, 5), 1'b1);
            end
            wait_idle("rand_drain");
        end
        check("rand_no_overflow", overflow, 1'b0);
        check("rand_no_timeout", timeout, 1'b0);

        // Overflow: one byte in flight plus four queued, the sixth is dropped
        ack_delay = 40;
        for (int i = 0; i < 5; i++) strobe(25'h0000040 + 25'(i), 8'h10 + 8'(i), 2, 1'b1);
        check("ovf_before", overflow, 1'b0);
        strobe(25'h0000050, 8'hEE, 2, 1'b0);
        check("ovf_after", overflow, 1'b1);
        wait_idle("ovf_drain");

        // Download end with bytes still queued
        ack_delay = 3;
        base = ack_count;
        strobe(25'h0000100, 8'h01, 2, 1'b1);
        strobe(25'h0010100, 8'h02, 2, 1'b1);
        strobe(25'h0000102, 8'h03, 2, 1'b1);
        ioctl_downl = 1'b0;
        n = 0;
        while (ack_count < base + 3 && n < 300) begin
            @(posedge clk_sys); #2; n++;
        end
        check("end_third_ack", ack_count, base + 3);
        check("end_not_loaded_yet", rom_loaded, 1'b0);
        n = 0;
        while (rom_loaded == 1'b0 && n < 20) begin
            @(negedge clk_sys); n++;
        end
        check("end_loaded_latency", n, 3);
        check("end_core_reset_held", core_reset, 1'b1);
        k = 0;
        while (core_reset == 1'b1 && k < HOLD_TB + 50) begin
            @(negedge clk_sys); k++;
        end
        check("end_core_reset_release", k, HOLD_TB + 1);

        // New download reasserts core reset; ack never returns for the first byte
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("dl_core_reset", core_reset, 1'b1);
        check("dl_rom_loaded_sticky", rom_loaded, 1'b1);
        ack_en = 1'b0;
        r0 = port1_req;
        ioctl_addr = 25'h0000200; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        exp_q.push_back(make_exp(25'h0000200, 8'h5A));
        n = 0;
        while (port1_req == r0 && n < 10) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            n++;
        end
        k = 0;
        while (timeout == 1'b0 && k < 400) begin
            @(negedge clk_sys);
            k++;
            if (k == 10) begin
                ioctl_addr = 25'h0012345; ioctl_dout = 8'hC3;
                exp_q.push_back(make_exp(25'h0012345, 8'hC3));
            end
            ioctl_wr = (k == 10);
        end
        check("to_cycles", k, 255);
        check("to_req_realigned", port1_req, port1_ack);
        ack_en = 1'b1;
        ack_delay = 2;
        wait_idle("to_next_issued");
        check("to_sticky", timeout, 1'b1);

        // Reset while a write is outstanding
        ack_en = 1'b0;
        strobe(25'h0000300, 8'h11, 2, 1'b1);
        strobe(25'h0000302, 8'h22, 2, 1'b1);
        strobe(25'h0000304, 8'h33, 2, 1'b1);
        repeat (3) @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_p1_req", port1_req, port1_ack);
        check("mid_rst_p2_req", port2_req, port2_ack);
        check("mid_rst_wr_we", wr_we, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_timeout", timeout, 1'b0);
        check("mid_rst_rom_loaded", rom_loaded, 1'b0);
        check("mid_rst_core_reset", core_reset, 1'b1);
        t1 = p1_tog; t2 = p2_tog;
        repeat (20) @(negedge clk_sys);
        check("mid_rst_quiet", (p1_tog - t1) + (p2_tog - t2), 0);
        ack_en = 1'b1;
        strobe(25'h0000400, 8'h77, 2, 1'b1);
        wait_idle("mid_rst_new_write");
        check("mid_rst_new_toggle", p1_tog - t1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
